// File: rtl/sym_fir_mac_engine.sv
// Symmetric/anti-symmetric FIR MAC: one output sample per start, NUM_PAIRS+4 cycles after iStart.
// No queuing: iStart is ignored while busy; a start in the oValid cycle is accepted.
module sym_fir_mac_engine #(
    parameter int WIDTH      = 16,
    parameter int DATA_WIDTH = 3,
    parameter int NUM_PAIRS  = 16,
    parameter int ACC_WIDTH  = 25,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 8
) (
    input  logic                              iClk12M,
    input  logic                              iRst,
    input  logic                              iStart,
    input  logic                              iAntiSym,
    output logic [$clog2(NUM_PAIRS+1)-1:0]    oTapIdx,
    input  logic signed [DATA_WIDTH-1:0]      iDelayHead,
    input  logic signed [DATA_WIDTH-1:0]      iDelayTail,
    input  logic signed [WIDTH-1:0]           iCoeff,
    output logic                              oBusy,
    output logic                              oValid,
    output logic signed [OUT_WIDTH-1:0]       oY,
    output logic                              oSat
);

    localparam int IDX_W  = $clog2(NUM_PAIRS + 1);
    localparam int PRE_W  = DATA_WIDTH + 1;
    localparam int PROD_W = WIDTH + DATA_WIDTH + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [IDX_W-1:0]       CENTRE_IDX = IDX_W'(NUM_PAIRS);
    localparam logic signed [ACC_WIDTH:0] RND_BIAS = (ACC_WIDTH+1)'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_WIDTH:0] Y_MAX    = (ACC_WIDTH+1)'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH:0] Y_MIN    = (ACC_WIDTH+1)'(-(2 ** (OUT_WIDTH - 1)));

    logic [1:0]                  state;
    logic [IDX_W-1:0]            tap_idx;
    logic                        anti;
    logic                        drain_cnt;
    logic                        busy;

    logic signed [PRE_W-1:0]     pre_q;
    logic signed [WIDTH-1:0]     coeff_q;
    logic                        pre_vld;
    logic signed [PROD_W-1:0]    prod_q;
    logic                        prod_vld;
    logic signed [ACC_WIDTH-1:0] acc;

    logic signed [PRE_W-1:0]     head_x;
    logic signed [PRE_W-1:0]     tail_x;
    logic signed [PRE_W-1:0]     pre_d;
    logic signed [ACC_WIDTH:0]   rnd_sum;
    logic signed [ACC_WIDTH:0]   r_val;
    logic signed [OUT_WIDTH-1:0] y_d;
    logic                        sat_d;

    assign head_x = {iDelayHead[DATA_WIDTH-1], iDelayHead};
    assign tail_x = {iDelayTail[DATA_WIDTH-1], iDelayTail};

    // The centre tap has no mirror partner, so only the head symbol contributes.
    always_comb begin
        pre_d = head_x;
        if (tap_idx != CENTRE_IDX) begin
            pre_d = anti ? (head_x - tail_x) : (head_x + tail_x);
        end
    end

    // Round-half-up then arithmetic shift, one guard bit so the bias cannot overflow.
    always_comb begin
        rnd_sum = $signed({acc[ACC_WIDTH-1], acc}) + RND_BIAS;
        r_val   = rnd_sum >>> SHIFT;
        sat_d   = 1'b0;
        y_d     = r_val[OUT_WIDTH-1:0];
        if (r_val > Y_MAX) begin
            sat_d = 1'b1;
            y_d   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end else if (r_val < Y_MIN) begin
            sat_d = 1'b1;
            y_d   = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state     <= ST_IDLE;
            tap_idx   <= '0;
            anti      <= 1'b0;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            pre_q     <= '0;
            coeff_q   <= '0;
            pre_vld   <= 1'b0;
            prod_q    <= '0;
            prod_vld  <= 1'b0;
            acc       <= '0;
            oValid    <= 1'b0;
            oY        <= '0;
            oSat      <= 1'b0;
        end else begin
            oValid   <= 1'b0;
            pre_vld  <= 1'b0;
            prod_vld <= pre_vld;

            if (pre_vld) begin
                prod_q <= PROD_W'(pre_q) * PROD_W'(coeff_q);
            end
            if (prod_vld) begin
                acc <= acc + ACC_WIDTH'(prod_q);
            end

            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        anti    <= iAntiSym;
                        acc     <= '0;
                        tap_idx <= '0;
                        busy    <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    pre_q   <= pre_d;
                    coeff_q <= iCoeff;
                    pre_vld <= 1'b1;
                    if (tap_idx == CENTRE_IDX) begin
                        tap_idx   <= '0;
                        drain_cnt <= 1'b0;
                        state     <= ST_DRAIN;
                    end else begin
                        tap_idx <= tap_idx + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= ST_OUT;
                    end
                end
                default: begin
                    oY     <= y_d;
                    oSat   <= sat_d;
                    oValid <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign oTapIdx = tap_idx;
    assign oBusy   = busy;

endmodule
